// File: rtl/bsg_nasti_client.sv
// NASTI slave endpoint: turns AW/W and AR bursts into tunnel requests and returns tunnel responses as R beats.
// Optional build macro BSG_NASTI_CLIENT_SLVERR_EN: partial-strobe W beats are swallowed and answered with SLVERR.

package bsg_nasti_pkg;
  typedef struct packed {
    logic [5:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } bsg_nasti_a_pkt;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } bsg_nasti_w_pkt;

  typedef struct packed {
    logic [5:0] id;
    logic [1:0] resp;
  } bsg_nasti_b_pkt;

  typedef struct packed {
    logic [5:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } bsg_nasti_r_pkt;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

package bsg_rocket_pkg;
  typedef struct packed {
    logic        op;
    logic [31:0] addr;
    logic [63:0] data;
  } bsg_tun_dmx_t;

  localparam logic TUN_OP_RD = 1'b0;
  localparam logic TUN_OP_WR = 1'b1;
endpackage

module bsg_nasti_client
  import bsg_nasti_pkg::*;
  import bsg_rocket_pkg::*;
(
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           nasti_aw_valid_i,
  input  bsg_nasti_a_pkt nasti_aw_data_i,
  output logic           nasti_aw_ready_o,
  input  logic           nasti_w_valid_i,
  input  bsg_nasti_w_pkt nasti_w_data_i,
  output logic           nasti_w_ready_o,
  output logic           nasti_b_valid_o,
  output bsg_nasti_b_pkt nasti_b_data_o,
  input  logic           nasti_b_ready_i,
  input  logic           nasti_ar_valid_i,
  input  bsg_nasti_a_pkt nasti_ar_data_i,
  output logic           nasti_ar_ready_o,
  output logic           nasti_r_valid_o,
  output bsg_nasti_r_pkt nasti_r_data_o,
  input  logic           nasti_r_ready_i,
  output logic           req_valid_o,
  output bsg_tun_dmx_t   req_data_o,
  input  logic           req_yumi_i,
  input  logic           resp_valid_i,
  input  bsg_tun_dmx_t   resp_data_i,
  output logic           resp_yumi_o
);

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_e;

  state_e         state_q;
  logic           prio_wr_q;
  logic           err_q;
  logic [5:0]     id_q;
  logic [31:0]    addr_q;
  logic [7:0]     len_q;
  logic [2:0]     size_q;
  logic [8:0]     beat_q;   // write beats taken, or read requests issued
  logic [7:0]     ret_q;    // read responses returned

  logic           grant_wr;
  logic           grant_rd;
  logic           w_hs;
  logic           req_hs;
  logic           r_last;
  logic [31:0]    addr_step;
  bsg_nasti_a_pkt a_sel;

`ifdef BSG_NASTI_CLIENT_SLVERR_EN
  logic beat_drop;
  logic unused_inputs;
  assign unused_inputs = ^{nasti_w_data_i.last, resp_data_i.op, resp_data_i.addr};
`else
  logic unused_inputs;
  assign unused_inputs = ^{nasti_w_data_i.last, nasti_w_data_i.strb, resp_data_i.op, resp_data_i.addr};
`endif

  assign addr_step = 32'd1 << size_q;
  assign a_sel     = grant_wr ? nasti_aw_data_i : nasti_ar_data_i;

  always_comb begin
    grant_wr         = 1'b0;
    grant_rd         = 1'b0;
    nasti_aw_ready_o = 1'b0;
    nasti_ar_ready_o = 1'b0;
    nasti_w_ready_o  = 1'b0;
    nasti_b_valid_o  = 1'b0;
    nasti_b_data_o   = '0;
    nasti_r_valid_o  = 1'b0;
    nasti_r_data_o   = '0;
    req_valid_o      = 1'b0;
    req_data_o       = '0;
    resp_yumi_o      = 1'b0;
    r_last           = 1'b0;
`ifdef BSG_NASTI_CLIENT_SLVERR_EN
    beat_drop        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        grant_wr         = ~reset_i & nasti_aw_valid_i & (~nasti_ar_valid_i | prio_wr_q);
        grant_rd         = ~reset_i & nasti_ar_valid_i & (~nasti_aw_valid_i | ~prio_wr_q);
        nasti_aw_ready_o = grant_wr;
        nasti_ar_ready_o = grant_rd;
      end
      WRITE: begin
`ifdef BSG_NASTI_CLIENT_SLVERR_EN
        beat_drop       = ~&nasti_w_data_i.strb;
        req_valid_o     = nasti_w_valid_i & ~beat_drop;
        nasti_w_ready_o = beat_drop | req_yumi_i;
`else
        req_valid_o     = nasti_w_valid_i;
        nasti_w_ready_o = req_yumi_i;
`endif
        if (req_valid_o)
          req_data_o = '{op: TUN_OP_WR, addr: addr_q, data: nasti_w_data_i.data};
      end
      WRESP: begin
        nasti_b_valid_o = 1'b1;
        nasti_b_data_o  = '{id: id_q, resp: (err_q ? RESP_SLVERR : RESP_OKAY)};
      end
      READ: begin
        req_valid_o = (beat_q <= {1'b0, len_q});
        if (req_valid_o)
          req_data_o = '{op: TUN_OP_RD, addr: addr_q, data: 64'h0};
        r_last          = (ret_q == len_q);
        nasti_r_valid_o = resp_valid_i;
        resp_yumi_o     = resp_valid_i & nasti_r_ready_i;
        if (resp_valid_i)
          nasti_r_data_o = '{id: id_q, data: resp_data_i.data, resp: RESP_OKAY, last: r_last};
      end
      default: ;
    endcase
  end

  assign w_hs   = nasti_w_valid_i & nasti_w_ready_o;
  assign req_hs = req_valid_o & req_yumi_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      prio_wr_q <= 1'b1;
      err_q     <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      beat_q    <= '0;
      ret_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_wr | grant_rd) begin
            id_q    <= a_sel.id;
            addr_q  <= a_sel.addr;
            len_q   <= a_sel.len;
            size_q  <= a_sel.size;
            beat_q  <= '0;
            ret_q   <= '0;
            err_q   <= 1'b0;
            // Fairness only matters when both channels contend.
            if (nasti_aw_valid_i & nasti_ar_valid_i)
              prio_wr_q <= ~prio_wr_q;
            state_q <= grant_wr ? WRITE : READ;
          end
        end
        WRITE: begin
          if (w_hs) begin
            addr_q <= addr_q + addr_step;
            beat_q <= beat_q + 9'd1;
`ifdef BSG_NASTI_CLIENT_SLVERR_EN
            if (beat_drop)
              err_q <= 1'b1;
`endif
            if (beat_q == {1'b0, len_q})
              state_q <= WRESP;
          end
        end
        WRESP: begin
          if (nasti_b_ready_i) begin
            err_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        READ: begin
          if (req_hs) begin
            addr_q <= addr_q + addr_step;
            beat_q <= beat_q + 9'd1;
          end
          if (resp_yumi_o) begin
            ret_q <= ret_q + 8'd1;
            if (r_last)
              state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_nasti_client.sv
// Directed bench for bsg_nasti_client: request/B/R scoreboards filled at stimulus time, checked by immediate assertions.
// Expectations follow BSG_NASTI_CLIENT_SLVERR_EN when it is defined for the build.

module tb_bsg_nasti_client;
  import bsg_nasti_pkg::*;
  import bsg_rocket_pkg::*;

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic           nasti_aw_valid_i, nasti_aw_ready_o;
  bsg_nasti_a_pkt nasti_aw_data_i;
  logic           nasti_w_valid_i, nasti_w_ready_o;
  bsg_nasti_w_pkt nasti_w_data_i;
  logic           nasti_b_valid_o, nasti_b_ready_i;
  bsg_nasti_b_pkt nasti_b_data_o;
  logic           nasti_ar_valid_i, nasti_ar_ready_o;
  bsg_nasti_a_pkt nasti_ar_data_i;
  logic           nasti_r_valid_o, nasti_r_ready_i;
  bsg_nasti_r_pkt nasti_r_data_o;
  logic           req_valid_o, req_yumi_i;
  bsg_tun_dmx_t   req_data_o;
  logic           resp_valid_i, resp_yumi_o;
  bsg_tun_dmx_t   resp_data_i;

  int total = 0;
  int bad   = 0;

  bsg_tun_dmx_t   exp_req_q[$];
  bsg_nasti_b_pkt exp_b_q[$];
  bsg_nasti_r_pkt exp_r_q[$];
  logic [63:0]    pend_q[$];

  always #5 clk_i = ~clk_i;

  bsg_nasti_client dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .nasti_aw_valid_i(nasti_aw_valid_i), .nasti_aw_data_i(nasti_aw_data_i), .nasti_aw_ready_o(nasti_aw_ready_o),
    .nasti_w_valid_i(nasti_w_valid_i), .nasti_w_data_i(nasti_w_data_i), .nasti_w_ready_o(nasti_w_ready_o),
    .nasti_b_valid_o(nasti_b_valid_o), .nasti_b_data_o(nasti_b_data_o), .nasti_b_ready_i(nasti_b_ready_i),
    .nasti_ar_valid_i(nasti_ar_valid_i), .nasti_ar_data_i(nasti_ar_data_i), .nasti_ar_ready_o(nasti_ar_ready_o),
    .nasti_r_valid_o(nasti_r_valid_o), .nasti_r_data_o(nasti_r_data_o), .nasti_r_ready_i(nasti_r_ready_i),
    .req_valid_o(req_valid_o), .req_data_o(req_data_o), .req_yumi_i(req_yumi_i),
    .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i), .resp_yumi_o(resp_yumi_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bsg_nasti_a_pkt mk_a(input logic [5:0] id, input logic [31:0] addr,
                                          input logic [7:0] len, input logic [2:0] size);
    return '{id: id, addr: addr, len: len, size: size};
  endfunction

  task automatic clear_inputs();
    nasti_aw_valid_i = 0; nasti_aw_data_i = '0;
    nasti_ar_valid_i = 0; nasti_ar_data_i = '0;
    nasti_w_valid_i  = 0; nasti_w_data_i  = '0;
    nasti_b_ready_i  = 0; nasti_r_ready_i = 0;
    req_yumi_i       = 0;
    resp_valid_i     = 0; resp_data_i     = '0;
  endtask

  task automatic addr_phase(input logic aw_v, input bsg_nasti_a_pkt aw, input logic ar_v,
                            input bsg_nasti_a_pkt ar, input logic exp_aw, input logic exp_ar);
    @(negedge clk_i);
    nasti_aw_valid_i = aw_v; nasti_aw_data_i = aw;
    nasti_ar_valid_i = ar_v; nasti_ar_data_i = ar;
    #1;
    chk("aw_ready", nasti_aw_ready_o, exp_aw);
    chk("ar_ready", nasti_ar_ready_o, exp_ar);
    @(posedge clk_i);
    #1;
    nasti_aw_valid_i = 0;
    nasti_ar_valid_i = 0;
  endtask

  task automatic write_data(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input bit rnd, input logic [7:0] strb1);
    int nreq = 0;
    int nexp = 0;
    bit err = 0;
    bit hs;
    bit drop;
    logic [63:0] d;
    logic [7:0] strb;
    logic [31:0] a;
    bsg_tun_dmx_t e;
    bsg_nasti_b_pkt eb;
    for (int i = 0; i <= int'(len); i++) begin
      a    = addr + 32'(i) * (32'd1 << size);
      d    = 64'hDEAD + 64'(i) * 64'h1_0000;
      strb = (i == 1) ? strb1 : 8'hFF;
`ifdef BSG_NASTI_CLIENT_SLVERR_EN
      drop = (strb != 8'hFF);
`else
      drop = 0;
`endif
      if (drop) err = 1;
      else begin
        exp_req_q.push_back('{op: TUN_OP_WR, addr: a, data: d});
        nexp++;
      end
      hs = 0;
      for (int c = 0; c < 50 && !hs; c++) begin
        @(negedge clk_i);
        nasti_w_valid_i = 1;
        nasti_w_data_i  = '{data: d, strb: strb, last: (i == int'(len))};
        req_yumi_i      = drop ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        #1;
        if (drop) begin
          chk("w_drop_ready", nasti_w_ready_o, 1'b1);
          chk("w_drop_req_valid", req_valid_o, 1'b0);
          hs = 1;
        end else begin
          chk("w_req_valid", req_valid_o, 1'b1);
          chk("w_ready", nasti_w_ready_o, req_yumi_i);
          if (req_yumi_i) begin
            e = exp_req_q.pop_front();
            chk("w_req_data", req_data_o, e);
            nreq++;
            hs = 1;
          end
        end
        @(posedge clk_i);
      end
      chk("w_beat_accepted", hs, 1'b1);
    end
    exp_b_q.push_back('{id: id, resp: (err ? RESP_SLVERR : RESP_OKAY)});
    @(negedge clk_i);
    nasti_w_valid_i = 0; req_yumi_i = 0; nasti_b_ready_i = 1;
    #1;
    chk("b_valid", nasti_b_valid_o, 1'b1);
    eb = exp_b_q.pop_front();
    chk("b_data", nasti_b_data_o, eb);
    chk("w_req_count", nreq, nexp);
    chk("ar_ready_in_wresp", nasti_ar_ready_o, 1'b0);
    @(posedge clk_i);
    @(negedge clk_i);
    nasti_b_ready_i = 0;
    #1;
    chk("b_valid_after", nasti_b_valid_o, 1'b0);
  endtask

  task automatic read_data(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input int abort_after);
    int nret = 0;
    int nreq = 0;
    bit done = 0;
    bit stalled = 0;
    bit push;
    bsg_nasti_r_pkt held = '0;
    bsg_nasti_r_pkt er;
    bsg_tun_dmx_t e;
    logic [63:0] newd = '0;
    for (int k = 0; k <= int'(len); k++)
      exp_req_q.push_back('{op: TUN_OP_RD, addr: addr + 32'(k) * (32'd1 << size), data: 64'h0});
    pend_q.delete();
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk_i);
      req_yumi_i      = 1'($urandom_range(0, 3) != 0);
      nasti_r_ready_i = 1'($urandom_range(0, 1));
      resp_valid_i    = (pend_q.size() > 0);
      resp_data_i     = resp_valid_i ? '{op: TUN_OP_RD, addr: 32'h0, data: pend_q[0]} : '0;
      #1;
      chk("r_valid", nasti_r_valid_o, resp_valid_i);
      chk("resp_yumi", resp_yumi_o, resp_valid_i & nasti_r_ready_i);
      chk("rd_req_valid", req_valid_o, (nreq <= int'(len)));
      if (stalled && nasti_r_valid_o) chk("r_hold", nasti_r_data_o, held);
      push = 0;
      if (req_valid_o && req_yumi_i && exp_req_q.size() > 0) begin
        e = exp_req_q.pop_front();
        chk("rd_req_data", req_data_o, e);
        newd = {32'hCAFE_0000 | 32'(nreq), e.addr};
        exp_r_q.push_back('{id: id, data: newd, resp: RESP_OKAY, last: (nreq == int'(len))});
        nreq++;
        push = 1;
      end
      if (nasti_r_valid_o && nasti_r_ready_i && exp_r_q.size() > 0) begin
        er = exp_r_q.pop_front();
        chk("r_data", nasti_r_data_o, er);
        void'(pend_q.pop_front());
        nret++;
        done = er.last;
      end
      stalled = nasti_r_valid_o & ~nasti_r_ready_i;
      held    = nasti_r_data_o;
      if (push) pend_q.push_back(newd);
      @(posedge clk_i);
      if (abort_after >= 0 && nret == abort_after) break;
    end
    if (abort_after < 0) begin
      chk("r_burst_done", done, 1'b1);
      @(negedge clk_i);
      req_yumi_i = 0; nasti_r_ready_i = 0; resp_valid_i = 0; resp_data_i = '0;
      #1;
      chk("rd_idle_req_valid", req_valid_o, 1'b0);
      chk("rd_idle_r_valid", nasti_r_valid_o, 1'b0);
      chk("rd_reqs_left", exp_req_q.size(), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset_i = 1;
    nasti_aw_valid_i = 1;
    nasti_aw_data_i  = mk_a(6'd1, 32'h10, 8'd0, 3'd3);
    #1;
    chk("rst_aw_ready", nasti_aw_ready_o, 1'b0);
    chk("rst_req_valid", req_valid_o, 1'b0);
    chk("rst_req_data", req_data_o, '0);
    chk("rst_b_valid", nasti_b_valid_o, 1'b0);
    chk("rst_r_valid", nasti_r_valid_o, 1'b0);
    repeat (2) @(negedge clk_i);
    nasti_aw_valid_i = 0;
    reset_i = 0;

    // contended pair after reset: write first
    addr_phase(1'b1, mk_a(6'd3, 32'h100, 8'd0, 3'd3), 1'b1, mk_a(6'd5, 32'h40, 8'd3, 3'd3), 1'b1, 1'b0);
    write_data(6'd3, 32'h100, 8'd0, 3'd3, 1'b0, 8'hFF);
    addr_phase(1'b0, '0, 1'b1, mk_a(6'd5, 32'h40, 8'd3, 3'd3), 1'b0, 1'b1);
    read_data(6'd5, 32'h40, 8'd3, 3'd3, -1);

    // second contended pair: read first
    addr_phase(1'b1, mk_a(6'd7, 32'h200, 8'd1, 3'd3), 1'b1, mk_a(6'd9, 32'h80, 8'd0, 3'd2), 1'b0, 1'b1);
    read_data(6'd9, 32'h80, 8'd0, 3'd2, -1);
    addr_phase(1'b1, mk_a(6'd7, 32'h200, 8'd1, 3'd3), 1'b0, '0, 1'b1, 1'b0);
    write_data(6'd7, 32'h200, 8'd1, 3'd3, 1'b1, 8'hFF);

    // 256 beats crossing the top of the address space
    addr_phase(1'b1, mk_a(6'd1, 32'hFFFF_FC00, 8'd255, 3'd3), 1'b0, '0, 1'b1, 1'b0);
    write_data(6'd1, 32'hFFFF_FC00, 8'd255, 3'd3, 1'b1, 8'hFF);
    chk("wrap_reqs_left", exp_req_q.size(), 0);

    // reset in the middle of a read
    addr_phase(1'b0, '0, 1'b1, mk_a(6'd2, 32'h1000, 8'd3, 3'd3), 1'b0, 1'b1);
    read_data(6'd2, 32'h1000, 8'd3, 3'd3, 2);
    @(negedge clk_i);
    reset_i = 1;
    resp_valid_i = 1; resp_data_i = '{op: TUN_OP_RD, addr: 32'h0, data: 64'h1234};
    nasti_r_ready_i = 1; req_yumi_i = 1; nasti_b_ready_i = 1;
    nasti_w_valid_i = 1; nasti_aw_valid_i = 1; nasti_ar_valid_i = 1;
    #1;
    chk("abort_req_valid", req_valid_o, 1'b0);
    chk("abort_req_data", req_data_o, '0);
    chk("abort_r_valid", nasti_r_valid_o, 1'b0);
    chk("abort_r_data", nasti_r_data_o, '0);
    chk("abort_resp_yumi", resp_yumi_o, 1'b0);
    chk("abort_b_valid", nasti_b_valid_o, 1'b0);
    chk("abort_w_ready", nasti_w_ready_o, 1'b0);
    chk("abort_aw_ready", nasti_aw_ready_o, 1'b0);
    chk("abort_ar_ready", nasti_ar_ready_o, 1'b0);
    clear_inputs();
    exp_req_q.delete(); exp_r_q.delete(); pend_q.delete();
    @(negedge clk_i);
    reset_i = 0;
    addr_phase(1'b1, mk_a(6'd4, 32'h300, 8'd0, 3'd2), 1'b0, '0, 1'b1, 1'b0);
    write_data(6'd4, 32'h300, 8'd0, 3'd2, 1'b0, 8'hFF);

    // partial strobe on the second beat
    addr_phase(1'b1, mk_a(6'd6, 32'h400, 8'd1, 3'd3), 1'b0, '0, 1'b1, 1'b0);
    write_data(6'd6, 32'h400, 8'd1, 3'd3, 1'b0, 8'h0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
